// File: rtl/pkg_ram.sv
// pkg_ram: shared dev_ram constants and the types used by the dev_ram arbiter
package pkg_ram;
  localparam int RAM_QUAD_SIZE = 64;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_RD_LAT = 1;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
  typedef struct packed {
    logic                     we;
    logic [ARB_ADDR_W-1:0]    addr;
    logic [RAM_QUAD_SIZE-1:0] wdata;
  } ram_req_t;
endpackage

// File: rtl/dev_ram_arb_rr.sv
// dev_ram_arb_rr: 2-way round-robin picker; last=1 means port 1 was served last
module dev_ram_arb_rr (
  input  logic [1:0] valid,
  input  logic       lock0,
  input  logic       last,
  output logic [1:0] grant
);
  logic v1;
  always_comb begin
    v1 = valid[1] & ~lock0;
    grant[0] = valid[0] & (~v1 | last);
    grant[1] = v1 & (~valid[0] | ~last);
  end
endmodule

// File: rtl/dev_ram_arbiter.sv
// dev_ram_arbiter: shares one dev_ram port between loader/CPU (port 0) and debugger (port 1)
module dev_ram_arbiter
  import pkg_ram::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = RAM_QUAD_SIZE,
  parameter int RD_LAT = ARB_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lock0,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);
  localparam int CW = RD_LAT < 2 ? 1 : $clog2(RD_LAT + 1);
  arb_state_t state, nxt;
  ram_req_t req;
  logic last, own, open, hs, win, cap;
  logic [1:0] grant;
  logic [CW-1:0] cnt;
  dev_ram_arb_rr u_rr (
    .valid({req1_valid, req0_valid}),
    .lock0(lock0),
    .last (last),
    .grant(grant)
  );
  // RESP is also an arbitration point so a new request can be accepted in the done cycle
  always_comb begin
    open = state == IDLE || state == RESP;
    req0_ready = open & grant[0];
    req1_ready = open & grant[1];
    hs = req0_ready | req1_ready;
    win = grant[1];
    cap = !req.we && ((state == ACCESS && RD_LAT == 1) || (state == WAIT && cnt == CW'(RD_LAT - 1)));
    nxt = open ? (hs ? ACCESS : IDLE)
        : state == ACCESS ? (req.we || RD_LAT == 1 ? RESP : WAIT)
        : cap ? RESP : state;
  end
  assign ram_en = state == ACCESS;
  assign ram_we = req.we;
  assign ram_addr = req.addr;
  assign ram_wdata = req.wdata;
  assign busy = state != IDLE;
  assign owner = own;
  assign req0_done = state == RESP && !own;
  assign req1_done = state == RESP && own;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      req <= '0;
      own <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      state <= nxt;
      cnt <= state == ACCESS ? CW'(1) : cnt + CW'(1);
      if (hs) begin
        req <= win ? {req1_we, req1_addr, req1_wdata} : {req0_we, req0_addr, req0_wdata};
        own <= win;
        last <= win;
      end
      if (cap && !own) req0_rdata <= ram_rdata;
      if (cap && own) req1_rdata <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_dev_ram_arbiter.sv
// tb_dev_ram_arbiter: directed checks of the dev_ram arbiter at read latency 1 and 3
module tb_dev_ram_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rst3_n, lock0;
  logic v0, v1, we0, we1;
  logic [31:0] a0, a1;
  logic [63:0] wd0, wd1;
  logic r0, r1, d0, d1, ram_en, ram_we, busy, owner;
  logic [63:0] rd0, rd1, ram_wdata, ram_rdata;
  logic [31:0] ram_addr;
  logic v31;
  logic [31:0] a31;
  logic r30, r31, d30, d31, en3, we3, busy3, owner3;
  logic [63:0] rd30, rd31, wdata3, rdata3;
  logic [31:0] addr3;
  int n_cmp = 0, n_bad = 0;
  int n0, n1, k;
  bit found;
  function automatic logic [63:0] dflt(input logic [7:0] a);
    return {56'h0, a ^ 8'hE3};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  dev_ram_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .lock0(lock0),
    .req0_valid(v0), .req0_ready(r0), .req0_we(we0), .req0_addr(a0), .req0_wdata(wd0),
    .req0_done(d0), .req0_rdata(rd0),
    .req1_valid(v1), .req1_ready(r1), .req1_we(we1), .req1_addr(a1), .req1_wdata(wd1),
    .req1_done(d1), .req1_rdata(rd1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );
  dev_ram_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .lock0(1'b0),
    .req0_valid(1'b0), .req0_ready(r30), .req0_we(1'b0), .req0_addr(32'h0), .req0_wdata(64'h0),
    .req0_done(d30), .req0_rdata(rd30),
    .req1_valid(v31), .req1_ready(r31), .req1_we(1'b0), .req1_addr(a31), .req1_wdata(64'h0),
    .req1_done(d31), .req1_rdata(rd31),
    .ram_en(en3), .ram_we(we3), .ram_addr(addr3), .ram_wdata(wdata3),
    .ram_rdata(rdata3), .busy(busy3), .owner(owner3)
  );
  // Latency-1 RAM: data is valid only during the strobe cycle
  logic [63:0] mem [256];
  logic [255:0] wr = '0;
  always @(posedge clk)
    if (ram_en && ram_we) begin
      mem[ram_addr[7:0]] <= ram_wdata;
      wr[ram_addr[7:0]] <= 1'b1;
    end
  assign ram_rdata = ram_en ? (wr[ram_addr[7:0]] ? mem[ram_addr[7:0]] : dflt(ram_addr[7:0])) : 64'hBAD;
  // Latency-3 RAM: data is valid only two cycles after the strobe
  logic [7:0] age3 = 8'd0;
  always @(posedge clk)
    age3 <= en3 ? 8'd1 : (age3 != 8'd0 && age3 != 8'hFF) ? age3 + 8'd1 : age3;
  assign rdata3 = (!en3 && age3 == 8'd2) ? dflt(addr3[7:0]) : 64'hBAD;
  initial begin
    rst_n = 0; rst3_n = 0; lock0 = 0;
    v0 = 0; v1 = 0; we0 = 0; we1 = 0; a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
    v31 = 0; a31 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_rdata0", rd0, 0);
    chk("rst_rdata1", rd1, 0);
    chk("rst_done", {d0, d1}, 0);
    chk("rst_ready", {r0, r1}, 0);
    chk("rst_ram_ctl", {ram_en, ram_we}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    @(negedge clk); rst_n = 1; rst3_n = 1;
    // write then back-to-back read on port 0
    @(negedge clk); v0 = 1; we0 = 1; a0 = 32'h10; wd0 = 64'h5A; #1;
    chk("t1_wr_ready", r0, 1);
    @(negedge clk); v0 = 0; #1;
    chk("t1_wr_en", ram_en, 1);
    chk("t1_wr_we", ram_we, 1);
    chk("t1_wr_addr", ram_addr, 32'h10);
    chk("t1_wr_wdata", ram_wdata, 64'h5A);
    chk("t1_wr_busy", busy, 1);
    chk("t1_wr_early_done", d0, 0);
    @(negedge clk); v0 = 1; we0 = 0; #1;
    chk("t1_wr_done", d0, 1);
    chk("t1_wr_en_off", ram_en, 0);
    chk("t1_rd_ready", r0, 1);
    @(negedge clk); v0 = 0; #1;
    chk("t1_rd_en", ram_en, 1);
    chk("t1_rd_we", ram_we, 0);
    @(negedge clk); #1;
    chk("t1_rd_done", d0, 1);
    chk("t1_rd_data", rd0, 64'h5A);
    chk("t1_rd1_quiet", rd1, 0);
    @(negedge clk); #1;
    chk("t1_idle_done", d0, 0);
    chk("t1_idle_busy", busy, 0);
    // both ports contend with 4 reads each
    n0 = 0; n1 = 0; k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      @(negedge clk);
      v0 = n0 < 4; a0 = 32'h40 + n0; we0 = 0;
      v1 = n1 < 4; a1 = 32'h50 + n1; we1 = 0;
      #1;
      if (r0 | r1) begin
        chk("t2_one_grant", r0 & r1, 0);
        chk("t2_grant_port", r1, k % 2 == 0);
        if (r1) n1++; else n0++;
        k++;
      end
    end
    chk("t2_grants", k, 8);
    @(negedge clk); v0 = 0; v1 = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("t2_rdata0", rd0, 64'hA0);
    chk("t2_rdata1", rd1, 64'hB0);
    // lock0 holds port 1 off until released
    @(negedge clk); lock0 = 1; v0 = 1; a0 = 32'h60; v1 = 1; a1 = 32'h61;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      chk("t3_lock_r1", r1, 0);
      if (r0) k++;
    end
    chk("t3_lock_grants", k, 6);
    @(negedge clk); lock0 = 0; v0 = 0;
    found = 0;
    for (int c = 0; c < 5 && !found; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      found = r1;
    end
    chk("t3_unlock_r1", found, 1);
    @(negedge clk); v1 = 0;
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk); #1;
      found = d1;
    end
    chk("t3_done1", found, 1);
    chk("t3_rdata1", rd1, 64'h82);
    // port 0 gives up before being served, then back-to-back handshake
    @(negedge clk); v1 = 1; a1 = 32'h70; #1;
    chk("t6_r1", r1, 1);
    @(negedge clk); v1 = 0; v0 = 1; a0 = 32'h71; #1;
    chk("t6_busy_r0", r0, 0);
    @(negedge clk); v0 = 0; #1;
    chk("t6_done1", d1, 1);
    chk("t6_rdata1", rd1, 64'h93);
    chk("t6_drop_r0", r0, 0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("t6_no_access", ram_en, 0);
    end
    @(negedge clk); v1 = 1; a1 = 32'h72; #1;
    chk("t6_b2b_r1", r1, 1);
    @(negedge clk); v1 = 0; #1;
    @(negedge clk); v0 = 1; a0 = 32'h73; #1;
    chk("t6_b2b_done1", d1, 1);
    chk("t6_b2b_r0", r0, 1);
    @(negedge clk); v0 = 0; #1;
    chk("t6_b2b_en", ram_en, 1);
    chk("t6_b2b_addr", ram_addr, 32'h73);
    chk("t6_b2b_owner", owner, 0);
    @(negedge clk); #1;
    chk("t6_b2b_done0", d0, 1);
    chk("t6_b2b_rdata0", rd0, 64'h90);
    chk("t6_b2b_rdata1", rd1, 64'h91);
    // read latency 3 on port 1
    @(negedge clk); v31 = 1; a31 = 32'h20; #1;
    chk("t4_ready", r31, 1);
    @(negedge clk); v31 = 0; #1;
    chk("t4_en_t1", en3, 1);
    chk("t4_busy_t1", busy3, 1);
    chk("t4_done_t1", d31, 0);
    @(negedge clk); #1;
    chk("t4_en_t2", en3, 0);
    chk("t4_busy_t2", busy3, 1);
    chk("t4_done_t2", d31, 0);
    @(negedge clk); #1;
    chk("t4_busy_t3", busy3, 1);
    chk("t4_done_t3", d31, 0);
    @(negedge clk); #1;
    chk("t4_done_t4", d31, 1);
    chk("t4_rdata", rd31, 64'hC3);
    chk("t4_busy_t4", busy3, 1);
    @(negedge clk); #1;
    chk("t4_busy_t5", busy3, 0);
    chk("t4_done_t5", d31, 0);
    // reset during the WAIT cycle of a read
    @(negedge clk); v31 = 1; a31 = 32'h21; #1;
    chk("t5_ready", r31, 1);
    @(negedge clk); v31 = 0;
    @(negedge clk); rst3_n = 0;
    @(negedge clk); rst3_n = 1; #1;
    chk("t5_done", d31, 0);
    chk("t5_rdata", rd31, 0);
    chk("t5_busy", busy3, 0);
    chk("t5_owner", owner3, 0);
    chk("t5_ram_ctl", {en3, we3}, 0);
    chk("t5_ram_addr", addr3, 0);
    chk("t5_ram_wdata", wdata3, 0);
    chk("t5_ready_off", r31, 0);
    found = 0;
    repeat (4) begin
      @(negedge clk); #1;
      found = found | d31;
    end
    chk("t5_no_done", found, 0);
    @(negedge clk); v31 = 1; #1;
    chk("t5_retry_ready", r31, 1);
    @(negedge clk); v31 = 0;
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk); #1;
      found = d31;
    end
    chk("t5_retry_done", found, 1);
    chk("t5_retry_rdata", rd31, 64'hC2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
